// File: rtl/scratch_pkg.sv
// Shared definitions for the scratch RAM / hardware stack block.
package scratch_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_PUSH,
    CMD_POP,
    CMD_WRITE
  } sp_cmd_e;

endpackage

// File: rtl/scratch_stack_ram_if.sv
// Command/data bundle between the datapath and the scratch stack RAM.
interface scratch_stack_ram_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic [ADDR_WIDTH-1:0] SCR_ADDR;
  logic                  SCR_WE;
  logic                  PUSH;
  logic                  POP;
  logic                  SP_LD;
  logic [ADDR_WIDTH-1:0] SP_IN;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic [ADDR_WIDTH-1:0] SP_OUT;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  FULL;
  logic                  EMPTY;
  logic                  OVF;
  logic                  UNF;

  modport master (
    output DATA_IN, SCR_ADDR, SCR_WE, PUSH, POP, SP_LD, SP_IN,
    input  DATA_OUT, SP_OUT, COUNT, FULL, EMPTY, OVF, UNF
  );

  modport slave (
    input  DATA_IN, SCR_ADDR, SCR_WE, PUSH, POP, SP_LD, SP_IN,
    output DATA_OUT, SP_OUT, COUNT, FULL, EMPTY, OVF, UNF
  );
endinterface

// File: rtl/scratch_ram_core.sv
// Single-port storage array: registered write, combinational or registered read.
module scratch_ram_core #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8,
  parameter int SYNC_READ  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents are zero at configuration and deliberately survive reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i && !rst) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (SYNC_READ != 0) begin : g_sync_read
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_comb_read
    assign rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/scratch_stack_ram.sv
// Scratch RAM with hardware stack pointer: command decode, SP/COUNT and sticky flags.
module scratch_stack_ram
  import scratch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SYNC_READ  = 0
) (
  input  logic              clk,
  input  logic              RST,
  scratch_stack_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  sp_cmd_e               cmd;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full, empty;
  logic [ADDR_WIDTH-1:0] sp_dec, sp_inc, sp_neg;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;

  assign full   = (count_q == COUNT_FULL);
  assign empty  = (count_q == '0);
  assign sp_dec = sp_q - ADDR_WIDTH'(1);
  assign sp_inc = sp_q + ADDR_WIDTH'(1);
  assign sp_neg = ADDR_WIDTH'(0) - bus.SP_IN;

  // Simultaneous PUSH and POP cancel each other and fall through to SCR_WE.
  always_comb begin
    cmd = CMD_NONE;
    if (bus.SP_LD) begin
      cmd = CMD_LOAD;
    end else if (bus.PUSH && !bus.POP) begin
      cmd = CMD_PUSH;
    end else if (bus.POP && !bus.PUSH) begin
      cmd = CMD_POP;
    end else if (bus.SCR_WE) begin
      cmd = CMD_WRITE;
    end
  end

  always_comb begin
    sp_d      = sp_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ram_we    = 1'b0;
    ram_waddr = bus.SCR_ADDR;
    case (cmd)
      CMD_LOAD: begin
        sp_d    = bus.SP_IN;
        count_d = {1'b0, sp_neg};
      end
      CMD_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = sp_dec;
          sp_d      = sp_dec;
          count_d   = count_q + (ADDR_WIDTH+1)'(1);
        end
      end
      CMD_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d    = sp_inc;
          count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
      end
      CMD_WRITE: ram_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ram_raddr = bus.POP ? sp_q : bus.SCR_ADDR;

  scratch_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SYNC_READ  (SYNC_READ)
  ) u_core (
    .clk     (clk),
    .rst     (RST),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.DATA_IN),
    .raddr_i (ram_raddr),
    .rdata_o (bus.DATA_OUT)
  );

  assign bus.SP_OUT = sp_q;
  assign bus.COUNT  = count_q;
  assign bus.FULL   = full;
  assign bus.EMPTY  = empty;
  assign bus.OVF    = ovf_q;
  assign bus.UNF    = unf_q;

endmodule

// File: tb/tb_scratch_stack_ram.sv
// Directed bench: default, 4-deep and registered-read instances of scratch_stack_ram.
module tb_scratch_stack_ram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  scratch_stack_ram_if #(.DATA_WIDTH(10), .ADDR_WIDTH(8)) bus_def ();
  scratch_stack_ram_if #(.DATA_WIDTH(10), .ADDR_WIDTH(2)) bus_sml ();
  scratch_stack_ram_if #(.DATA_WIDTH(10), .ADDR_WIDTH(8)) bus_syn ();

  scratch_stack_ram #(.DATA_WIDTH(10), .ADDR_WIDTH(8), .SYNC_READ(0)) u_def (
    .clk(clk), .RST(rst), .bus(bus_def));
  scratch_stack_ram #(.DATA_WIDTH(10), .ADDR_WIDTH(2), .SYNC_READ(0)) u_sml (
    .clk(clk), .RST(rst), .bus(bus_sml));
  scratch_stack_ram #(.DATA_WIDTH(10), .ADDR_WIDTH(8), .SYNC_READ(1)) u_syn (
    .clk(clk), .RST(rst), .bus(bus_syn));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_def.DATA_IN = '0; bus_def.SCR_ADDR = '0; bus_def.SCR_WE = 0;
    bus_def.PUSH = 0; bus_def.POP = 0; bus_def.SP_LD = 0; bus_def.SP_IN = '0;
    bus_sml.DATA_IN = '0; bus_sml.SCR_ADDR = '0; bus_sml.SCR_WE = 0;
    bus_sml.PUSH = 0; bus_sml.POP = 0; bus_sml.SP_LD = 0; bus_sml.SP_IN = '0;
    bus_syn.DATA_IN = '0; bus_syn.SCR_ADDR = '0; bus_syn.SCR_WE = 0;
    bus_syn.PUSH = 0; bus_syn.POP = 0; bus_syn.SP_LD = 0; bus_syn.SP_IN = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    #2;
    checks++; if (bus_def.SP_OUT !== 8'd0) begin errors++; $display("FAIL reset_sp got=%0d exp=0", bus_def.SP_OUT); end
    checks++; if (bus_def.COUNT !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus_def.COUNT); end
    checks++; if (bus_def.EMPTY !== 1'b1 || bus_def.FULL !== 1'b0) begin errors++; $display("FAIL reset_empty_full got=%b%b exp=10", bus_def.EMPTY, bus_def.FULL); end
    checks++; if (bus_def.OVF !== 1'b0 || bus_def.UNF !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bus_def.OVF, bus_def.UNF); end
    checks++; if (bus_syn.DATA_OUT !== 10'h000) begin errors++; $display("FAIL reset_sync_dout got=%h exp=000", bus_syn.DATA_OUT); end
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_push_pop();
    bus_def.PUSH = 1; bus_def.DATA_IN = 10'h155;
    tick();
    bus_def.DATA_IN = 10'h0AA;
    tick();
    bus_def.PUSH = 0;
    checks++; if (bus_def.SP_OUT !== 8'd254) begin errors++; $display("FAIL push_sp got=%0d exp=254", bus_def.SP_OUT); end
    checks++; if (bus_def.COUNT !== 9'd2) begin errors++; $display("FAIL push_count got=%0d exp=2", bus_def.COUNT); end
    bus_def.SCR_ADDR = 8'd255; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h155) begin errors++; $display("FAIL ram255 got=%h exp=155", bus_def.DATA_OUT); end
    bus_def.SCR_ADDR = 8'd254; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h0AA) begin errors++; $display("FAIL ram254 got=%h exp=0aa", bus_def.DATA_OUT); end
    bus_def.SCR_ADDR = 8'd0;
    bus_def.POP = 1; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h0AA) begin errors++; $display("FAIL pop1_data got=%h exp=0aa", bus_def.DATA_OUT); end
    tick();
    checks++; if (bus_def.DATA_OUT !== 10'h155) begin errors++; $display("FAIL pop2_data got=%h exp=155", bus_def.DATA_OUT); end
    tick();
    bus_def.POP = 0;
    checks++; if (bus_def.SP_OUT !== 8'd0 || bus_def.EMPTY !== 1'b1) begin errors++; $display("FAIL pop_final sp=%0d empty=%b exp sp=0 empty=1", bus_def.SP_OUT, bus_def.EMPTY); end
  endtask

  task automatic test_overflow_underflow();
    logic [9:0] exp_pop [4];
    exp_pop = '{10'd4, 10'd3, 10'd2, 10'd1};
    bus_sml.PUSH = 1;
    for (int i = 1; i <= 4; i++) begin
      bus_sml.DATA_IN = 10'(i);
      tick();
    end
    checks++; if (bus_sml.FULL !== 1'b1 || bus_sml.COUNT !== 3'd4 || bus_sml.OVF !== 1'b0) begin errors++; $display("FAIL sml_full full=%b count=%0d ovf=%b exp 1/4/0", bus_sml.FULL, bus_sml.COUNT, bus_sml.OVF); end
    bus_sml.DATA_IN = 10'd5;
    tick();
    bus_sml.PUSH = 0;
    checks++; if (bus_sml.OVF !== 1'b1 || bus_sml.SP_OUT !== 2'd0 || bus_sml.COUNT !== 3'd4) begin errors++; $display("FAIL sml_ovf ovf=%b sp=%0d count=%0d exp 1/0/4", bus_sml.OVF, bus_sml.SP_OUT, bus_sml.COUNT); end
    bus_sml.SCR_ADDR = 2'd0; #1;
    checks++; if (bus_sml.DATA_OUT !== 10'd4) begin errors++; $display("FAIL sml_ovf_nowrite got=%0d exp=4", bus_sml.DATA_OUT); end
    bus_sml.POP = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus_sml.DATA_OUT !== exp_pop[i]) begin errors++; $display("FAIL sml_pop%0d got=%0d exp=%0d", i, bus_sml.DATA_OUT, exp_pop[i]); end
      tick();
    end
    checks++; if (bus_sml.EMPTY !== 1'b1 || bus_sml.SP_OUT !== 2'd0 || bus_sml.UNF !== 1'b0) begin errors++; $display("FAIL sml_drained empty=%b sp=%0d unf=%b exp 1/0/0", bus_sml.EMPTY, bus_sml.SP_OUT, bus_sml.UNF); end
    checks++; if (bus_sml.DATA_OUT !== 10'd4) begin errors++; $display("FAIL sml_unf_data got=%0d exp=4", bus_sml.DATA_OUT); end
    tick();
    bus_sml.POP = 0;
    checks++; if (bus_sml.UNF !== 1'b1 || bus_sml.SP_OUT !== 2'd0 || bus_sml.COUNT !== 3'd0) begin errors++; $display("FAIL sml_unf unf=%b sp=%0d count=%0d exp 1/0/0", bus_sml.UNF, bus_sml.SP_OUT, bus_sml.COUNT); end
    tick();
    checks++; if (bus_sml.OVF !== 1'b1) begin errors++; $display("FAIL sml_ovf_sticky got=%b exp=1", bus_sml.OVF); end
  endtask

  task automatic test_priority();
    bus_def.PUSH = 1; bus_def.POP = 1; bus_def.SCR_WE = 1;
    bus_def.SCR_ADDR = 8'h10; bus_def.DATA_IN = 10'h3FF;
    tick();
    bus_def.PUSH = 0; bus_def.POP = 0; bus_def.SCR_WE = 0;
    checks++; if (bus_def.SP_OUT !== 8'd0 || bus_def.COUNT !== 9'd0 || bus_def.UNF !== 1'b0) begin errors++; $display("FAIL pushpop_ignored sp=%0d count=%0d unf=%b exp 0/0/0", bus_def.SP_OUT, bus_def.COUNT, bus_def.UNF); end
    #1;
    checks++; if (bus_def.DATA_OUT !== 10'h3FF) begin errors++; $display("FAIL pushpop_scr_we got=%h exp=3ff", bus_def.DATA_OUT); end
    bus_def.SCR_WE = 1; bus_def.DATA_IN = 10'h222; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h3FF) begin errors++; $display("FAIL no_write_through got=%h exp=3ff", bus_def.DATA_OUT); end
    tick();
    bus_def.SCR_WE = 0;
    checks++; if (bus_def.DATA_OUT !== 10'h222) begin errors++; $display("FAIL write_landed got=%h exp=222", bus_def.DATA_OUT); end
    bus_def.PUSH = 1; bus_def.SCR_WE = 1; bus_def.SCR_ADDR = 8'h20; bus_def.DATA_IN = 10'h111;
    tick();
    bus_def.PUSH = 0; bus_def.SCR_WE = 0;
    checks++; if (bus_def.SP_OUT !== 8'd255 || bus_def.COUNT !== 9'd1) begin errors++; $display("FAIL push_wins sp=%0d count=%0d exp 255/1", bus_def.SP_OUT, bus_def.COUNT); end
    #1;
    checks++; if (bus_def.DATA_OUT !== 10'h000) begin errors++; $display("FAIL scr_we_dropped got=%h exp=000", bus_def.DATA_OUT); end
    bus_def.SCR_ADDR = 8'd255; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h111) begin errors++; $display("FAIL push_data got=%h exp=111", bus_def.DATA_OUT); end
  endtask

  task automatic test_sp_load();
    bus_def.SP_LD = 1; bus_def.SP_IN = 8'hF0;
    tick();
    checks++; if (bus_def.SP_OUT !== 8'hF0 || bus_def.COUNT !== 9'd16) begin errors++; $display("FAIL sp_load sp=%h count=%0d exp f0/16", bus_def.SP_OUT, bus_def.COUNT); end
    bus_def.SP_IN = 8'h80; bus_def.PUSH = 1; bus_def.DATA_IN = 10'h0AB;
    tick();
    bus_def.PUSH = 0;
    checks++; if (bus_def.SP_OUT !== 8'h80 || bus_def.COUNT !== 9'd128) begin errors++; $display("FAIL sp_load_push sp=%h count=%0d exp 80/128", bus_def.SP_OUT, bus_def.COUNT); end
    bus_def.SCR_ADDR = 8'hEF; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h000) begin errors++; $display("FAIL push_dropped_ef got=%h exp=000", bus_def.DATA_OUT); end
    bus_def.SCR_ADDR = 8'h7F; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h000) begin errors++; $display("FAIL push_dropped_7f got=%h exp=000", bus_def.DATA_OUT); end
    bus_def.SP_IN = 8'h00;
    tick();
    bus_def.SP_LD = 0;
    checks++; if (bus_def.COUNT !== 9'd0 || bus_def.EMPTY !== 1'b1) begin errors++; $display("FAIL sp_load_zero count=%0d empty=%b exp 0/1", bus_def.COUNT, bus_def.EMPTY); end
  endtask

  task automatic test_sync_read();
    bus_syn.SCR_WE = 1; bus_syn.SCR_ADDR = 8'd5; bus_syn.DATA_IN = 10'h123;
    tick();
    bus_syn.SCR_WE = 0;
    checks++; if (bus_syn.DATA_OUT !== 10'h000) begin errors++; $display("FAIL sync_old_first got=%h exp=000", bus_syn.DATA_OUT); end
    tick();
    checks++; if (bus_syn.DATA_OUT !== 10'h123) begin errors++; $display("FAIL sync_read got=%h exp=123", bus_syn.DATA_OUT); end
    bus_syn.SCR_ADDR = 8'd6; #1;
    checks++; if (bus_syn.DATA_OUT !== 10'h123) begin errors++; $display("FAIL sync_latency got=%h exp=123", bus_syn.DATA_OUT); end
    tick();
    checks++; if (bus_syn.DATA_OUT !== 10'h000) begin errors++; $display("FAIL sync_addr6 got=%h exp=000", bus_syn.DATA_OUT); end
    bus_syn.SCR_ADDR = 8'd5; bus_syn.SCR_WE = 1; bus_syn.DATA_IN = 10'h045;
    tick();
    bus_syn.SCR_WE = 0;
    checks++; if (bus_syn.DATA_OUT !== 10'h123) begin errors++; $display("FAIL sync_same_cycle got=%h exp=123", bus_syn.DATA_OUT); end
    tick();
    checks++; if (bus_syn.DATA_OUT !== 10'h045) begin errors++; $display("FAIL sync_new got=%h exp=045", bus_syn.DATA_OUT); end
  endtask

  task automatic test_async_reset();
    bus_def.PUSH = 1; bus_def.DATA_IN = 10'h301;
    tick();
    bus_def.DATA_IN = 10'h302;
    tick();
    bus_def.DATA_IN = 10'h303;
    #2;
    rst = 1;
    #1;
    checks++; if (bus_def.SP_OUT !== 8'd0 || bus_def.COUNT !== 9'd0 || bus_def.EMPTY !== 1'b1) begin errors++; $display("FAIL async_rst sp=%0d count=%0d empty=%b exp 0/0/1", bus_def.SP_OUT, bus_def.COUNT, bus_def.EMPTY); end
    checks++; if (bus_syn.DATA_OUT !== 10'h000) begin errors++; $display("FAIL async_rst_sync got=%h exp=000", bus_syn.DATA_OUT); end
    checks++; if (bus_sml.OVF !== 1'b0 || bus_sml.UNF !== 1'b0) begin errors++; $display("FAIL async_rst_flags got=%b%b exp=00", bus_sml.OVF, bus_sml.UNF); end
    tick();
    rst = 0;
    bus_def.PUSH = 0;
    bus_def.SCR_ADDR = 8'd255; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h301) begin errors++; $display("FAIL retain255 got=%h exp=301", bus_def.DATA_OUT); end
    bus_def.SCR_ADDR = 8'd254; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h302) begin errors++; $display("FAIL retain254 got=%h exp=302", bus_def.DATA_OUT); end
    bus_def.SCR_ADDR = 8'd253; #1;
    checks++; if (bus_def.DATA_OUT !== 10'h000) begin errors++; $display("FAIL rst_write_suppressed got=%h exp=000", bus_def.DATA_OUT); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow_underflow();
    test_priority();
    test_sp_load();
    test_sync_read();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scratch_stack_ram.md
# scratch_stack_ram

Parametrised scratch RAM with an integrated hardware stack pointer for the RAT CPU datapath. It serves direct-addressed LD/ST traffic and PUSH/POP/CALL/RET stack traffic from one storage array. It owns SP, occupancy tracking and sticky overflow/underflow flags. Read mode is selectable: combinational, or registered with one cycle of latency.

## Interface
- DATA_WIDTH, 10, word width
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH
- SYNC_READ, 0, 0 = combinational read, 1 = registered read
- clk  in  1  rising-edge clock
- RST  in  1  reset, asynchronous and active-high
- DATA_IN  in  DATA_WIDTH  write data for a direct write or a push
- SCR_ADDR  in  ADDR_WIDTH  direct read/write address
- SCR_WE  in  1  direct write enable
- PUSH  in  1  push DATA_IN
- POP  in  1  pop the top of stack
- SP_LD  in  1  load SP from SP_IN
- SP_IN  in  ADDR_WIDTH  new SP value
- DATA_OUT  out  DATA_WIDTH  read data
- SP_OUT  out  ADDR_WIDTH  current SP
- COUNT  out  ADDR_WIDTH+1  stack occupancy, 0..DEPTH
- FULL, EMPTY  out  1  COUNT==DEPTH, COUNT==0 (combinational from COUNT)
- OVF, UNF  out  1  sticky overflow / underflow flags

## Operation
- Stack grows downward; SP points at the current top.
  - Push: writes ram[SP-1 mod DEPTH], then SP <= SP-1.
  - Pop: reads ram[SP], then SP <= SP+1.
  - SP arithmetic wraps modulo DEPTH.
- Per-cycle command priority:
  1. SP_LD
  2. Exactly one of PUSH/POP
  3. SCR_WE
- SP_LD: SP <= SP_IN; COUNT <= (DEPTH - SP_IN) mod DEPTH, so SP_IN=0 gives COUNT 0. Any PUSH/POP/SCR_WE in that cycle is dropped.
- PUSH and POP asserted together: both ignored. SP, COUNT and flags unchanged. SCR_WE is still honoured.
- Push while FULL: no write, SP and COUNT unchanged, OVF <= 1.
- Pop while EMPTY: SP and COUNT unchanged, UNF <= 1. DATA_OUT still shows ram[SP].
- Any accepted push or pop drops SCR_WE in the same cycle.
- Read address: SP when POP is asserted, otherwise SCR_ADDR.
- A direct write to the address being read shows old data on DATA_OUT in that cycle; no write-through.
- RST clears SP, COUNT, OVF, UNF and the SYNC_READ output register.
  - RST does not clear the array.
  - The array initialises to all zeros at configuration only.
- OVF and UNF clear only on RST.

## Timing
- SYNC_READ=0: DATA_OUT = ram[rd_addr] combinationally; the write takes effect at the next rising edge.
- SYNC_READ=1: DATA_OUT is registered with 1-cycle latency.
  - It updates every cycle from the rd_addr captured at the edge.
  - It reads pre-write contents when read and write hit the same address.
- SP_OUT, COUNT, OVF and UNF update on the rising edge after the command.
- FULL and EMPTY follow COUNT combinationally.
- Reset values while RST is high, asynchronously: SP_OUT=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0; DATA_OUT=0 when SYNC_READ=1.
- RST asserted mid-operation: the in-flight write for that edge is suppressed.
- Back-to-back push/pop every cycle is supported with no bubbles.

## Structure
- Shared package scratch_pkg:
  - default-width localparams
  - typedef sp_cmd_e {CMD_NONE, CMD_LOAD, CMD_PUSH, CMD_POP, CMD_WRITE} for priority decode
- Sub-module scratch_ram_core: parametrised single-port array with registered write and optional registered read.
- Top level holds the command decoder, SP/COUNT counters and flags.

## Test plan
- Reset, then PUSH 0x155 then 0x0AA (defaults) -> ram[255]=0x155, ram[254]=0x0AA, SP_OUT=254, COUNT=2; POP, POP -> DATA_OUT 0x0AA then 0x155, SP_OUT=0, EMPTY=1.
- ADDR_WIDTH=2: push 4 words -> FULL=1; fifth push -> OVF=1, SP_OUT=0, COUNT=4, contents unchanged; pop from empty -> UNF=1.
- PUSH+POP together with SCR_WE=1, SCR_ADDR=0x10, DATA_IN=0x3FF -> SP/COUNT unchanged, ram[0x10]=0x3FF; PUSH+SCR_WE -> only the push lands.
- SP_LD with SP_IN=0xF0 -> SP_OUT=0xF0, COUNT=16; SP_LD with PUSH in the same cycle -> push dropped.
- SYNC_READ=1: write 0x123 to addr 5, read addr 5 -> DATA_OUT=0x123 exactly one cycle later; same-cycle read/write shows old value.
- Assert RST asynchronously mid-push burst -> outputs go to reset values immediately; previously stored array words are retained.
